wb_arbiter: RTL and testbench

- Writer-side counterpart of the 64-bit, 32-entry register file. Drives the regfile write port (reg_write, write_register, write_data).
- Merges two result producers into that single write port: the ALU (single-cycle) and load returns (variable latency).
- Provides read-port bypass so operands read in the same cycle as a pending write see the new value.
- Sits between execute/memory stages and the regfile.

---
 rtl/rv_pkg.sv | 18 +
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_arbiter.sv | 103 ++++++++++
 tb/tb_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback source-select type.
package rv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // x0 is hardwired to zero in the regfile; writes to it are dropped here.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Which producer owns the write port in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_LD   = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO buffering load returns until they win the write port.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a reset drops every buffered entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns onto the
// single regfile write port, and bypasses the pending write onto read operands.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int LD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [XLEN-1:0]       write_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_rf,
  input  logic [XLEN-1:0]       rs2_rf,
  output logic [XLEN-1:0]       rs1_val,
  output logic [XLEN-1:0]       rs2_val,
  output logic                  ld_pending
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(LD_DEPTH + 1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    head_entry;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  ld_push;
  logic                  ld_pop;
  wb_sel_e               sel;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]       win_data;

  assign ld_ready   = (fifo_count != CNT_W'(LD_DEPTH));
  assign ld_push    = ld_valid && ld_ready;
  assign ld_pending = (fifo_count != '0);
  assign {head_rd, head_data} = head_entry;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ld_push),
    .push_data ({ld_rd, ld_data}),
    .pop       (ld_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A full FIFO must drain first so loads cannot stall forever behind a busy
  // ALU; otherwise the ALU has priority and loads fill idle slots.
  always_comb begin
    sel       = SEL_NONE;
    alu_ready = !fifo_full;
    if (fifo_full)        sel = SEL_LD;
    else if (alu_valid)   sel = SEL_ALU;
    else if (!fifo_empty) sel = SEL_LD;
    ld_pop   = (sel == SEL_LD);
    win_rd   = (sel == SEL_ALU) ? alu_rd   : head_rd;
    win_data = (sel == SEL_ALU) ? alu_data : head_data;
  end

  // Register the winner onto the write port; an x0 winner is consumed but
  // leaves address and data untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (sel != SEL_NONE && win_rd != ZERO_REG) begin
      reg_write      <= 1'b1;
      write_register <= win_rd;
      write_data     <= win_data;
    end else begin
      reg_write      <= 1'b0;
    end
  end

  // Forward the write in flight to any operand reading the same register.
  always_comb begin
    rs1_val = rs1_rf;
    rs2_val = rs2_rf;
    if (reg_write && rs1_addr != ZERO_REG && write_register == rs1_addr) rs1_val = write_data;
    if (reg_write && rs2_addr != ZERO_REG && write_register == rs2_addr) rs2_val = write_data;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a queue-based model.
module tb_wb_arbiter;

  localparam int XLEN     = 64;
  localparam int LD_DEPTH = 2;

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            reg_write;
  logic [4:0]      write_register;
  logic [XLEN-1:0] write_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_rf;
  logic [XLEN-1:0] rs2_rf;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            ld_pending;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  wb_arbiter #(.XLEN(XLEN), .LD_DEPTH(LD_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_valid       (ld_valid),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_rf         (rs1_rf),
    .rs2_rf         (rs2_rf),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .ld_pending     (ld_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            m_rw = 1'b0;
  logic [4:0]      m_wr = '0;
  logic [XLEN-1:0] m_wd = '0;

  // Per edge: a full buffer drains, otherwise ALU first, then oldest load.
  always @(posedge clk or posedge reset) begin : model
    ent_t w;
    bit   have;
    bit   was_full;
    if (reset) begin
      mq.delete();
      m_rw <= 1'b0;
      m_wr <= '0;
      m_wd <= '0;
    end else begin
      have     = 0;
      was_full = (mq.size() == LD_DEPTH);
      if (was_full) begin
        w = mq.pop_front(); have = 1;
      end else if (alu_valid) begin
        w.rd = alu_rd; w.data = alu_data; have = 1;
      end else if (mq.size() > 0) begin
        w = mq.pop_front(); have = 1;
      end
      if (ld_valid && !was_full) mq.push_back('{ld_rd, ld_data});
      if (have && w.rd != 5'd0) begin
        m_rw <= 1'b1;
        m_wr <= w.rd;
        m_wd <= w.data;
      end else begin
        m_rw <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      check("reg_write", reg_write, m_rw);
      check("write_register", write_register, m_wr);
      check("write_data", write_data, m_wd);
      check("ld_pending", ld_pending, mq.size() != 0);
      check("ld_ready", ld_ready, mq.size() != LD_DEPTH);
      if (alu_valid) check("alu_ready", alu_ready, mq.size() != LD_DEPTH);
      check("rs1_val", rs1_val,
            (m_rw && m_wr == rs1_addr && rs1_addr != 5'd0) ? m_wd : rs1_rf);
      check("rs2_val", rs2_val,
            (m_rw && m_wr == rs2_addr && rs2_addr != 5'd0) ? m_wd : rs2_rf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [63:0] ldd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
  endtask

  // Contention table: ALU held until accepted, three loads offered.
  int t_av[8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
  int t_ard[8] = '{3, 4, 5, 5, 6, 6, 0, 0};
  int t_lv[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
  int t_lrd[8] = '{10, 11, 12, 12, 0, 0, 0, 0};

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rs1_addr = 0; rs2_addr = 0; rs1_rf = 0; rs2_rf = 0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_reg_write", reg_write, 0);
    check("rst_write_register", write_register, 0);
    check("rst_write_data", write_data, 0);
    check("rst_ld_pending", ld_pending, 0);
    check("rst_ld_ready", ld_ready, 1);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1;

    // ALU only, then bypass of the fresh write
    @(negedge clk);
    drive(1, 5'd1, 64'd5, 0, 0, 0);
    #2 check("alu_only_ready", alu_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rs1_addr = 5'd1; rs1_rf = 64'd0;
    #2;
    check("alu_only_we", reg_write, 1);
    check("alu_only_reg", write_register, 1);
    check("alu_only_data", write_data, 5);
    check("alu_only_bypass", rs1_val, 5);

    // Load only
    @(negedge clk);
    rs1_addr = 0;
    drive(0, 0, 0, 1, 5'd2, 64'd6);
    #2 check("ld_only_ready", ld_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("ld_only_pending", ld_pending, 1);
    check("ld_only_we_early", reg_write, 0);
    @(negedge clk);
    #2;
    check("ld_only_pending_clr", ld_pending, 0);
    check("ld_only_we", reg_write, 1);
    check("ld_only_reg", write_register, 2);
    check("ld_only_data", write_data, 6);

    // x0 destination
    @(negedge clk);
    drive(1, 5'd0, 64'd8, 0, 0, 0);
    #2 check("x0_ready", alu_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rs1_addr = 5'd0; rs1_rf = 64'h123;
    #2;
    check("x0_we", reg_write, 0);
    check("x0_reg_hold", write_register, 2);
    check("x0_data_hold", write_data, 6);
    check("x0_rs1", rs1_val, 64'h123);
    rs1_rf = 0;

    // Contention
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(t_av[c] != 0, 5'(t_ard[c]), 64'h100 + 64'(t_ard[c]),
            t_lv[c] != 0, 5'(t_lrd[c]), 64'hA00 + 64'(t_lrd[c]));
      #2;
      case (c)
        1: check("ct_c1_reg", write_register, 3);
        2: begin
          check("ct_c2_alu_ready", alu_ready, 0);
          check("ct_c2_ld_ready", ld_ready, 0);
          check("ct_c2_reg", write_register, 4);
        end
        3: begin
          check("ct_c3_reg", write_register, 10);
          check("ct_c3_data", write_data, 64'hA0A);
          check("ct_c3_alu_ready", alu_ready, 1);
        end
        4: begin
          check("ct_c4_reg", write_register, 5);
          check("ct_c4_alu_ready", alu_ready, 0);
        end
        5: check("ct_c5_reg", write_register, 11);
        6: check("ct_c6_reg", write_register, 6);
        7: begin
          check("ct_c7_reg", write_register, 12);
          check("ct_c7_pending", ld_pending, 0);
        end
        default: ;
      endcase
    end

    // Wrap: five loads streamed through a two-entry buffer
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(0, 0, 0, c < 5, 5'(20 + c), 64'hB00 + 64'(20 + c));
      #2;
      if (c == 2) begin
        check("wrap_first_reg", write_register, 20);
        check("wrap_first_data", write_data, 64'hB14);
      end
      if (c == 6) begin
        check("wrap_last_we", reg_write, 1);
        check("wrap_last_reg", write_register, 24);
        check("wrap_last_data", write_data, 64'hB18);
        check("wrap_drained", ld_pending, 0);
      end
    end

    // Reset with two loads buffered
    @(negedge clk);
    drive(1, 5'd7, 64'h77, 1, 5'd30, 64'hC30);
    @(negedge clk);
    drive(1, 5'd8, 64'h88, 1, 5'd31, 64'hC31);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    check("mid_rst_we", reg_write, 0);
    check("mid_rst_pending", ld_pending, 0);
    check("mid_rst_ld_ready", ld_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      check("post_rst_we", reg_write, 0);
      check("post_rst_pending", ld_pending, 0);
    end

    // Randomized traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rs1_rf   = {$urandom, $urandom};
      rs2_rf   = {$urandom, $urandom};
    end

    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
